// File: rtl/cache_line_array_if.sv
// Bus bundle between the cache controller (master) and one way's line array (slave).
// Read port: rd_en/rd_index request, rdata/rdata_valid/rvalid/rdirty response one cycle later.
// Write port: wr_en/wr_index/wmask/wdata/wr_dirty, byte-masked.
// Maintenance: inval_all pulse starts a clear-all sequence, busy reports it in progress.
interface cache_line_array_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic             rd_en;
  logic [IDX_W-1:0] rd_index;
  logic [WIDTH-1:0] rdata;
  logic             rdata_valid;
  logic             rvalid;
  logic             rdirty;
  logic             wr_en;
  logic [IDX_W-1:0] wr_index;
  logic [WIDTH/8-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic             wr_dirty;
  logic             inval_all;
  logic             busy;

  modport master (
    output rd_en, rd_index, wr_en, wr_index, wmask, wdata, wr_dirty, inval_all,
    input  rdata, rdata_valid, rvalid, rdirty, busy
  );

  modport slave (
    input  rd_en, rd_index, wr_en, wr_index, wmask, wdata, wr_dirty, inval_all,
    output rdata, rdata_valid, rvalid, rdirty, busy
  );
endinterface

// File: rtl/cache_line_array.sv
// Cache line data/metadata store: DEPTH lines of WIDTH bits with per-line valid and dirty.
// Ports:
//   clk   - clock, all state changes on posedge
//   rst_n - asynchronous active-low reset (metadata and outputs only; line data is not reset)
//   bus   - cache_line_array_if slave: byte-masked write port, registered read port with
//           write-first bypass, and an invalidate-all engine that zeroes one line per cycle.
module cache_line_array #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  cache_line_array_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned NB    = WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] dirty_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             idle_go;
  logic             wr_go;
  logic             rd_go;
  logic             same_idx;
  logic [WIDTH-1:0] merged;

  // inval_all takes priority over any read/write presented in the same idle cycle.
  always_comb begin
    idle_go  = (state_q == StIdle) && !bus.inval_all;
    wr_go    = idle_go && bus.wr_en && rst_n;
    rd_go    = idle_go && bus.rd_en;
    same_idx = wr_go && (bus.wr_index == bus.rd_index);
  end

  // Post-write line content; also used as the write-first bypass value.
  always_comb begin
    merged = mem_q[bus.wr_index];
    for (int b = 0; b < NB; b++) begin
      if (bus.wmask[b]) merged[8*b +: 8] = bus.wdata[8*b +: 8];
    end
  end

  // Line data has no reset; the clear engine is the only way to zero it.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_go) begin
      mem_q[bus.wr_index] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      valid_q         <= '0;
      dirty_q         <= '0;
      bus.busy        <= 1'b0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
      bus.rvalid      <= 1'b0;
      bus.rdirty      <= 1'b0;
    end else begin
      bus.rdata_valid <= rd_go;
      if (rd_go) begin
        if (same_idx) begin
          bus.rdata  <= merged;
          bus.rvalid <= 1'b1;
          bus.rdirty <= bus.wr_dirty;
        end else begin
          bus.rdata  <= mem_q[bus.rd_index];
          bus.rvalid <= valid_q[bus.rd_index];
          bus.rdirty <= dirty_q[bus.rd_index];
        end
      end

      if (wr_go) begin
        valid_q[bus.wr_index] <= 1'b1;
        dirty_q[bus.wr_index] <= bus.wr_dirty;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.inval_all) begin
            state_q  <= StClear;
            cnt_q    <= '0;
            bus.busy <= 1'b1;
          end
        end
        StClear: begin
          valid_q[cnt_q] <= 1'b0;
          dirty_q[cnt_q] <= 1'b0;
          // Natural wrap brings the counter back to 0 on the last line.
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q  <= StIdle;
            bus.busy <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
